// File: rtl/alu_sequencer_if.sv
// Operand/opcode/result bundle between the sequencer and its board-facing driver.
// The slave side is the sequencer; the master side drives switches/buttons and the ALU result.
interface alu_sequencer_if #(
    parameter int NB_DATA      = 4,
    parameter int NB_OPERATION = 4
);
    logic [NB_DATA-1:0]      i_data;
    logic                    i_enter;
    logic                    i_clear;
    logic [NB_DATA-1:0]      i_alu_result;
    logic [NB_DATA-1:0]      o_data_a;
    logic [NB_DATA-1:0]      o_data_b;
    logic [NB_OPERATION-1:0] o_op;
    logic [NB_DATA-1:0]      o_result;
    logic                    o_result_valid;
    logic [1:0]              o_state;

    modport slave (
        input  i_data, i_enter, i_clear, i_alu_result,
        output o_data_a, o_data_b, o_op, o_result, o_result_valid, o_state
    );

    modport master (
        output i_data, i_enter, i_clear, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_result, o_result_valid, o_state
    );
endinterface

// File: rtl/alu_sequencer.sv
// Push-button sequencer: loads operand A, operand B, opcode, then captures the ALU result.
// Define ALU_SEQUENCER_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter on the button.
module alu_sequencer #(
    parameter int NB_DATA         = 4,
    parameter int NB_OPERATION    = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            i_clock,
    input  logic            i_reset,
    alu_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RES = 2'b11
    } state_t;

    if (NB_OPERATION > NB_DATA || DEBOUNCE_CYCLES < 0) begin : g_bad_param
        $error("alu_sequencer: NB_OPERATION must not exceed NB_DATA, DEBOUNCE_CYCLES must be >= 0");
    end

    state_t                  state_q, state_d;
    logic                    enter_meta, enter_sync, enter_filt, enter_prev, enter_pulse;
    logic                    load_a, load_b, load_op, capture, clr_valid;
    logic [NB_DATA-1:0]      data_a_q, data_b_q, result_q;
    logic [NB_OPERATION-1:0] op_q;
    logic                    valid_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            enter_meta <= 1'b0;
            enter_sync <= 1'b0;
        end else begin
            enter_meta <= bus.i_enter;
            enter_sync <= enter_meta;
        end
    end

`ifdef ALU_SEQUENCER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_level;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive edge of disagreement; agreement restarts the count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (enter_sync == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_cnt   <= '0;
            deb_level <= enter_sync;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign enter_filt = deb_level;
`else
    assign enter_filt = enter_sync;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) enter_prev <= 1'b0;
        else         enter_prev <= enter_filt;
    end

    assign enter_pulse = enter_filt & ~enter_prev;

    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= S_A;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_op   = 1'b0;
        capture   = 1'b0;
        clr_valid = 1'b0;
        if (bus.i_clear) begin
            state_d   = S_A;
            clr_valid = 1'b1;
        end else begin
            unique case (state_q)
                S_A:  if (enter_pulse) begin load_a  = 1'b1; state_d = S_B;   end
                S_B:  if (enter_pulse) begin load_b  = 1'b1; state_d = S_OP;  end
                S_OP: if (enter_pulse) begin load_op = 1'b1; state_d = S_RES; end
                S_RES: begin
                    if (enter_pulse) begin
                        clr_valid = 1'b1;
                        state_d   = S_A;
                    end else if (!valid_q) begin
                        capture = 1'b1;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    // Operands and opcode are stable for the whole of S_RES, so the first S_RES edge sees a settled ALU.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_a_q <= '0;
            data_b_q <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (load_a)  data_a_q <= bus.i_data;
            if (load_b)  data_b_q <= bus.i_data;
            if (load_op) op_q     <= bus.i_data[NB_OPERATION-1:0];
            if (capture) result_q <= bus.i_alu_result;
            if (clr_valid)    valid_q <= 1'b0;
            else if (capture) valid_q <= 1'b1;
        end
    end

    assign bus.o_data_a       = data_a_q;
    assign bus.o_data_b       = data_b_q;
    assign bus.o_op           = op_q;
    assign bus.o_result       = result_q;
    assign bus.o_result_valid = valid_q;
    assign bus.o_state        = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an a+b ALU model and a result scoreboard.
// Latency expectations follow ALU_SEQUENCER_DEBOUNCE_EN when it is defined for the build.
module tb_alu_sequencer;

`ifdef ALU_SEQUENCER_DEBOUNCE_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [3:0] exp_q[$];
    logic       valid_d = 1'b0;

    alu_sequencer_if #(.NB_DATA(4), .NB_OPERATION(4)) bus ();

    alu_sequencer #(
        .NB_DATA(4), .NB_OPERATION(4), .DEBOUNCE_CYCLES(16)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.i_alu_result = bus.o_data_a + bus.o_data_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press, hold until the advance has taken effect, then release until the edge detector re-arms.
    task automatic press(input logic [3:0] d);
        bus.i_data  = d;
        bus.i_enter = 1'b1;
        tick(LAT + 3);
        bus.i_enter = 1'b0;
        tick(LAT + 3);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] a, b, op, res,
                           input logic vld, input logic [1:0] st);
        chk({tag, "_a"},     bus.o_data_a, a);
        chk({tag, "_b"},     bus.o_data_b, b);
        chk({tag, "_op"},    bus.o_op, op);
        chk({tag, "_res"},   bus.o_result, res);
        chk({tag, "_vld"},   bus.o_result_valid, vld);
        chk({tag, "_state"}, bus.o_state, st);
    endtask

    // Scoreboard pop on each rising edge of result_valid.
    always @(negedge clk) begin
        if (bus.o_result_valid && !valid_d) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                chk("sb_result", bus.o_result, exp_q.pop_front());
            end
        end
        valid_d <= bus.o_result_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_data  = 4'd0;
        bus.i_enter = 1'b0;
        bus.i_clear = 1'b0;

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_all("reset", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00);

        // Exact advance latency and single advance for a held press.
        bus.i_data  = 4'd3;
        bus.i_enter = 1'b1;
        tick(LAT + 2);
        chk("lat_before", bus.o_state, 2'b00);
        tick(1);
        chk("lat_at_k2", bus.o_state, 2'b01);
        chk("lat_a", bus.o_data_a, 4'd3);
        bus.i_data = 4'd9;
        tick(50);
        chk("hold_state", bus.o_state, 2'b01);
        chk("hold_a", bus.o_data_a, 4'd3);
        bus.i_enter = 1'b0;
        tick(LAT + 3);

        press(4'd5);
        chk("s_op_state", bus.o_state, 2'b10);
        exp_q.push_back(4'd8);
        press(4'd4);
        bus.i_data = 4'hF;
        tick(2);
        chk_all("sum", 4'd3, 4'd5, 4'd4, 4'd8, 1'b1, 2'b11);

        press(4'd9);
        chk_all("res_exit", 4'd3, 4'd5, 4'd4, 4'd8, 1'b0, 2'b00);

        // Clear collides with an enter pulse in S_OP.
        press(4'd6);
        press(4'd2);
        chk("pre_clear_state", bus.o_state, 2'b10);
        bus.i_data  = 4'd7;
        bus.i_enter = 1'b1;
        tick(LAT + 2);
        bus.i_clear = 1'b1;
        tick(1);
        bus.i_clear = 1'b0;
        chk_all("clear_vs_enter", 4'd6, 4'd2, 4'd4, 4'd8, 1'b0, 2'b00);
        bus.i_enter = 1'b0;
        tick(LAT + 3);

        press(4'd6);
        press(4'd2);
        exp_q.push_back(4'd8);
        press(4'd1);
        tick(1);
        chk_all("second_op", 4'd6, 4'd2, 4'd1, 4'd8, 1'b1, 2'b11);
        bus.i_clear = 1'b1;
        tick(1);
        bus.i_clear = 1'b0;
        chk_all("clear_in_res", 4'd6, 4'd2, 4'd1, 4'd8, 1'b0, 2'b00);

`ifdef ALU_SEQUENCER_DEBOUNCE_EN
        bus.i_data  = 4'd11;
        bus.i_enter = 1'b1;
        tick(5);
        bus.i_enter = 1'b0;
        tick(LAT + 5);
        chk("glitch_state", bus.o_state, 2'b00);
        chk("glitch_a", bus.o_data_a, 4'd6);
`endif

        // Reset mid-sequence.
        press(4'd4);
        chk("pre_reset_state", bus.o_state, 2'b01);
        rst = 1'b1;
        bus.i_enter = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.i_enter = 1'b0;
        chk_all("mid_reset", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00);
        tick(LAT + 4);
        chk("post_reset_state", bus.o_state, 2'b00);

        chk("sb_drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
